vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parameterised VGA raster timing generator with registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BP      = 64,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          blank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0) ||
        (longint'(c_H_TOTAL) > (longint'(1) << CW)) ||
        (longint'(c_V_TOTAL) > (longint'(1) << CW))) begin : g_bad_params
        $error("vga_timing_gen: invalid timing parameters");
    end

    localparam logic [CW-1:0] c_ONE      = CW'(1);
    localparam logic [CW-1:0] c_H_LAST   = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST   = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          run_q, run_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          blank_q, blank_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    // run_q marks that the raster is live; the first enabled edge after idle
    // presents (0,0) with both start pulses instead of advancing the counters.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        run_d = run_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        if (!enable) begin
            h_d   = '0;
            v_d   = '0;
            run_d = 1'b0;
        end else if (!run_q) begin
            h_d   = '0;
            v_d   = '0;
            run_d = 1'b1;
            ls_d  = 1'b1;
            fs_d  = 1'b1;
        end else if (pix_en) begin
            if (h_q == c_H_LAST) begin
                h_d  = '0;
                ls_d = 1'b1;
                if (v_q == c_V_LAST) begin
                    v_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    v_d = v_q + c_ONE;
                end
            end else begin
                h_d = h_q + c_ONE;
            end
        end
    end

    always_comb begin
        hsync_d = ((h_d >= c_HS_START) && (h_d < c_HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = ((v_d >= c_VS_START) && (v_d < c_VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        de_d    = run_d && (h_d < c_H_ACT) && (v_d < c_V_ACT);
        blank_d = ~de_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            run_q   <= 1'b0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            de_q    <= 1'b0;
            blank_q <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            run_q   <= run_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign x           = h_q;
    assign y           = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign blank       = blank_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire
